// File: rtl/sample_interleaver.sv
// Buffers per-channel samples in two small FIFOs and streams them as an alternating ch0/ch1 slot per cycle.
// Output slot is registered (one cycle after the FSM decision); no back-pressure from the core, so empty slots are zero-filled and counted.
module sample_interleaver #(
  parameter int DATA_W     = 7,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 8,
  localparam int AW        = $clog2(FIFO_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clr_stat,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_ch,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] data_out,
  output logic [1:0]        ch_sel_out,
  output logic              valid_out,
  output logic [AW:0]       fill0,
  output logic [AW:0]       fill1,
  output logic              underflow,
  output logic [CNT_W-1:0]  underflow_cnt
);

  typedef enum logic [0:0] {IDLE, RUN} state_t;

  state_t             state_q, state_d;
  logic               next_ch_q, next_ch_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               ch_q, ch_d;
  logic               valid_q, valid_d;
  logic               uf_q, uf_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [AW:0]        wr_ptr_q [2];
  logic [AW:0]        wr_ptr_d [2];
  logic [AW:0]        rd_ptr_q [2];
  logic [AW:0]        rd_ptr_d [2];
  logic [DATA_W-1:0]  mem0_q [FIFO_DEPTH];
  logic [DATA_W-1:0]  mem1_q [FIFO_DEPTH];
  logic [1:0]         full, empty, push_sel, pop_sel;
  logic               push;

  // Extra pointer MSB distinguishes full from empty when the low bits match.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      full[i]  = (wr_ptr_q[i][AW] != rd_ptr_q[i][AW]) &&
                 (wr_ptr_q[i][AW-1:0] == rd_ptr_q[i][AW-1:0]);
      empty[i] = (wr_ptr_q[i] == rd_ptr_q[i]);
    end
  end

  assign in_ready = in_ch ? !full[1] : !full[0];
  assign push     = in_valid && in_ready;
  assign push_sel = {push && in_ch, push && !in_ch};

  always_comb begin
    state_d   = state_q;
    next_ch_d = next_ch_q;
    data_d    = '0;
    ch_d      = 1'b0;
    valid_d   = 1'b0;
    uf_d      = uf_q;
    cnt_d     = cnt_q;
    pop_sel   = 2'b00;
    case (state_q)
      IDLE: begin
        if (en && !empty[0] && !empty[1]) begin
          state_d   = RUN;
          next_ch_d = 1'b0;
        end
      end
      RUN: begin
        // Stopping only at a pair boundary keeps ch0/ch1 aligned for the core.
        if (!next_ch_q && !en) begin
          state_d = IDLE;
        end else begin
          valid_d   = 1'b1;
          ch_d      = next_ch_q;
          next_ch_d = !next_ch_q;
          if (!empty[next_ch_q]) begin
            pop_sel[next_ch_q] = 1'b1;
            data_d = next_ch_q ? mem1_q[rd_ptr_q[1][AW-1:0]] : mem0_q[rd_ptr_q[0][AW-1:0]];
          end else begin
            uf_d = 1'b1;
            if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (clr_stat) begin
      uf_d  = 1'b0;
      cnt_d = '0;
    end
    for (int i = 0; i < 2; i++) begin
      wr_ptr_d[i] = wr_ptr_q[i] + {{AW{1'b0}}, push_sel[i]};
      rd_ptr_d[i] = rd_ptr_q[i] + {{AW{1'b0}}, pop_sel[i]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      next_ch_q <= 1'b0;
      data_q    <= '0;
      ch_q      <= 1'b0;
      valid_q   <= 1'b0;
      uf_q      <= 1'b0;
      cnt_q     <= '0;
      for (int i = 0; i < 2; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      next_ch_q <= next_ch_d;
      data_q    <= data_d;
      ch_q      <= ch_d;
      valid_q   <= valid_d;
      uf_q      <= uf_d;
      cnt_q     <= cnt_d;
      for (int i = 0; i < 2; i++) begin
        wr_ptr_q[i] <= wr_ptr_d[i];
        rd_ptr_q[i] <= rd_ptr_d[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_sel[0]) mem0_q[wr_ptr_q[0][AW-1:0]] <= in_data;
    if (push_sel[1]) mem1_q[wr_ptr_q[1][AW-1:0]] <= in_data;
  end

  assign data_out      = data_q;
  assign ch_sel_out    = {1'b0, ch_q};
  assign valid_out     = valid_q;
  assign fill0         = wr_ptr_q[0] - rd_ptr_q[0];
  assign fill1         = wr_ptr_q[1] - rd_ptr_q[1];
  assign underflow     = uf_q;
  assign underflow_cnt = cnt_q;

endmodule

// File: tb/tb_sample_interleaver.sv
// Directed bench for sample_interleaver: stimulus queues expected slots, a negedge monitor pops and compares them.
module tb_sample_interleaver;

  logic       clk, rst, en, clr_stat, in_ch, in_valid, in_ready, valid_out, underflow;
  logic [6:0] in_data, data_out;
  logic [1:0] ch_sel_out;
  logic [2:0] fill0, fill1;
  logic [7:0] underflow_cnt;

  typedef struct packed {
    logic [6:0] d;
    logic [1:0] ch;
  } slot_t;

  slot_t sb[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  sample_interleaver #(.DATA_W(7), .FIFO_DEPTH(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .clr_stat(clr_stat),
    .in_data(in_data), .in_ch(in_ch), .in_valid(in_valid), .in_ready(in_ready),
    .data_out(data_out), .ch_sel_out(ch_sel_out), .valid_out(valid_out),
    .fill0(fill0), .fill1(fill1), .underflow(underflow), .underflow_cnt(underflow_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input bit ch, input int v, input bit exp_rdy);
    in_ch    = ch;
    in_data  = v[6:0];
    in_valid = 1'b1;
    #1;
    chk("in_ready", int'(in_ready), int'(exp_rdy));
    tick();
    in_valid = 1'b0;
  endtask

  task automatic expect_slot(input int v, input bit ch);
    slot_t s;
    s.d  = v[6:0];
    s.ch = {1'b0, ch};
    sb.push_back(s);
  endtask

  // Monitor: every valid slot must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && valid_out) begin
      if (sb.size() == 0) begin
        chk("unexpected_slot", int'($signed(data_out)), 999);
      end else begin
        slot_t e;
        e = sb.pop_front();
        chk("slot_data", int'($signed(data_out)), int'($signed(e.d)));
        chk("slot_ch", int'(ch_sel_out), int'(e.ch));
      end
    end
  end

  initial begin
    int ecnt;
    bit euf;
    rst = 1'b1; en = 1'b0; clr_stat = 1'b0; in_ch = 1'b0; in_valid = 1'b0; in_data = '0;
    #1;
    chk("rst_valid", int'(valid_out), 0);
    chk("rst_data", int'(data_out), 0);
    chk("rst_ch", int'(ch_sel_out), 0);
    chk("rst_fill0", int'(fill0), 0);
    chk("rst_uf", int'(underflow), 0);
    chk("rst_cnt", int'(underflow_cnt), 0);
    #11 rst = 1'b0;
    tick();

    // Prime and stream four pairs
    push(0, 60, 1); push(0, 55, 1); push(0, -30, 1); push(0, -23, 1);
    push(1, 50, 1); push(1, 40, 1); push(1, -20, 1); push(1, -25, 1);
    chk("prime_fill0", int'(fill0), 4);
    chk("prime_fill1", int'(fill1), 4);
    expect_slot(60, 0); expect_slot(50, 1); expect_slot(55, 0); expect_slot(40, 1);
    expect_slot(-30, 0); expect_slot(-20, 1); expect_slot(-23, 0); expect_slot(-25, 1);
    en = 1'b1;
    repeat (9) tick();
    en = 1'b0;
    tick(); tick();
    chk("stream_uf", int'(underflow), 0);
    chk("stream_fill0", int'(fill0), 0);

    // Overflow, then refused push during a pop of the full FIFO
    push(0, 11, 1); push(0, 12, 1); push(0, 13, 1); push(0, 14, 1);
    push(0, 15, 0);
    chk("ovf_fill0", int'(fill0), 4);
    push(1, 21, 1); push(1, 22, 1); push(1, 23, 1); push(1, 24, 1);
    expect_slot(11, 0); expect_slot(21, 1); expect_slot(12, 0); expect_slot(22, 1);
    expect_slot(13, 0); expect_slot(23, 1); expect_slot(14, 0); expect_slot(24, 1);
    en = 1'b1;
    tick();
    in_ch = 1'b0; in_data = 7'd7; in_valid = 1'b1;
    #1;
    chk("pushpop_refused", int'(in_ready), 0);
    tick();
    chk("pushpop_next_rdy", int'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    chk("pushpop_fill0", int'(fill0), 4);
    repeat (6) tick();
    en = 1'b0;
    tick(); tick();
    chk("after_fill0", int'(fill0), 1);
    chk("after_fill1", int'(fill1), 0);

    // en dropped while ch1 due: ch1 still emitted
    push(1, 8, 1);
    expect_slot(7, 0); expect_slot(8, 1);
    en = 1'b1;
    tick(); tick();
    en = 1'b0;
    tick(); tick(); tick();
    chk("stop1_fill1", int'(fill1), 0);

    // en dropped while ch0 due: no further slot
    push(0, 31, 1); push(1, 32, 1); push(0, 33, 1); push(1, 34, 1);
    expect_slot(31, 0); expect_slot(32, 1);
    en = 1'b1;
    tick(); tick(); tick();
    en = 1'b0;
    repeat (4) tick();
    chk("stop0_fill0", int'(fill0), 1);
    chk("stop0_fill1", int'(fill1), 1);

    // Async reset mid-RUN
    expect_slot(33, 0);
    en = 1'b1;
    tick(); tick();
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("arst_valid", int'(valid_out), 0);
    chk("arst_data", int'(data_out), 0);
    chk("arst_fill0", int'(fill0), 0);
    chk("arst_fill1", int'(fill1), 0);
    #1 rst = 1'b0;
    repeat (5) tick();
    en = 1'b0;
    tick();

    // Underflow with a clear that coincides with a zero-fill, then saturation
    push(0, 6, 1); push(1, -5, 1);
    expect_slot(6, 0); expect_slot(-5, 1);
    for (int k = 0; k < 418; k++) expect_slot(0, k[0]);
    ecnt = 0; euf = 1'b0;
    en = 1'b1;
    for (int i = 0; i < 421; i++) begin
      clr_stat = (i == 150);
      tick();
      if (i == 150) begin
        ecnt = 0; euf = 1'b0;
      end else if (i >= 3) begin
        euf = 1'b1;
        if (ecnt < 255) ecnt++;
      end
      chk("uf_flag", int'(underflow), int'(euf));
      chk("uf_cnt", int'(underflow_cnt), ecnt);
    end
    clr_stat = 1'b0;
    en = 1'b0;
    tick(); tick();
    chk("sat_cnt", int'(underflow_cnt), 255);
    clr_stat = 1'b1;
    tick();
    clr_stat = 1'b0;
    chk("clr_uf", int'(underflow), 0);
    chk("clr_cnt", int'(underflow_cnt), 0);

    repeat (3) tick();
    chk("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sample_interleaver.md
Name: sample_interleaver

Overview:
Transmit-side source for the spike-sorting feature core. It buffers per-channel 7-bit signed samples from an acquisition front end. It emits them as the strictly alternating, one-sample-per-cycle `data`/`ch_sel` stream that the feature core consumes (ch0, ch1, ch0, ...). It has no back-pressure from the core, so it owns gap handling (zero fill) and reports underflow statistics.

Parameters:
DATA_W, 7, sample width (two's complement)
FIFO_DEPTH, 4, entries per channel FIFO; power of 2, >= 2
CNT_W, 8, width of saturating underflow counter

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
en  in  1  stream enable
clr_stat  in  1  synchronous clear of underflow flag/counter
in_data  in  DATA_W  sample to buffer
in_ch  in  1  target channel FIFO (0/1)
in_valid  in  1  sample offered
in_ready  out  1  selected FIFO not full
data_out  out  DATA_W  sample to feature core
ch_sel_out  out  2  channel tag {1'b0, ch}
valid_out  out  1  slot valid
fill0  out  log2(FIFO_DEPTH)+1  ch0 FIFO occupancy
fill1  out  log2(FIFO_DEPTH)+1  ch1 FIFO occupancy
underflow  out  1  sticky: a slot was zero-filled
underflow_cnt  out  CNT_W  zero-filled slot count, saturating

Behaviour:
- Reset (async, rst=1): FIFOs empty, state IDLE, next channel = 0; data_out=0, ch_sel_out=0, valid_out=0, underflow=0, underflow_cnt=0. Reset mid-stream discards all buffered samples immediately.
- Write side:
  - in_ready = !full(in_ch), combinational.
  - Push when in_valid && in_ready.
  - There is no pass-through: a push into a full FIFO is refused even if that FIFO pops in the same cycle.
  - Push and pop on the same FIFO in one cycle are both honoured; occupancy stays unchanged.
- Occupancy: fill0/fill1 reflect registered occupancy after the previous edge (0..FIFO_DEPTH).
- FSM:
  - IDLE: valid_out=0, data_out=0, ch_sel_out=0. Go to RUN when en=1 && fill0>=1 && fill1>=1 (priming guarantees the first pair is real data).
  - RUN: every cycle emits one registered slot for the next channel, then toggles next channel.
    - Non-empty FIFO: pop it; data_out = head.
    - Empty FIFO: data_out=0, valid_out=1, no pop; underflow<=1; underflow_cnt increments, saturating at all-ones.
    - If en=0 is sampled when next channel = 0, go to IDLE without emitting. A pair is never split: if en drops while ch1 is due, ch1 is still emitted.
- Timing: output registered, one-cycle latency from FSM decision to port. A sample pushed at edge N can appear on data_out no earlier than edge N+1.
- ch_sel_out[1] is always 0.
- clr_stat=1 clears underflow and underflow_cnt at the edge. If clr_stat and an underflow coincide in the same cycle, clear wins and the count is 0.
- FIFO pointers wrap modulo FIFO_DEPTH; full/empty use an extra pointer bit.

Test Plan:
- Reset then prime: push ch0 {60,55,-30,-23} and ch1 {50,40,-20,-25}, then en=1 → valid_out stream data_out 60,50,55,40,-30,-20,-23,-25 with ch_sel_out 0,1,0,1,0,1,0,1; underflow stays 0.
- Overflow: with en=0, push 5 samples to ch0 (FIFO_DEPTH=4) → in_ready=0 on the 5th, fill0=4, 5th value never emitted.
- Underflow: prime one pair (6,-5), hold en=1, no further pushes → 6,-5 then 0,0,... with underflow=1 and underflow_cnt incrementing by 1 per slot; with CNT_W=8 it saturates at 255. clr_stat=1 → both return to 0.
- Stop alignment: en dropped while ch1 is due → ch1 sample still emitted, then valid_out=0 in IDLE. en dropped while ch0 is due → no further slot.
- Simultaneous push/pop: ch0 full (4), push 7 to ch0 in a cycle where ch0 pops → refused (in_ready=0); push in the next cycle accepted, fill0 back to 4.
- Async reset mid-RUN: assert rst between clock edges → outputs 0 immediately, fill0=fill1=0; after release, no output until re-primed.
